// File: rtl/dac_multichannel_driver_if.sv
// rtl/dac_multichannel_driver_if.sv - control, sample and DAC port bundle for the multichannel DAC driver
interface dac_multichannel_driver_if #(
  parameter int NCH    = 2,
  parameter int DW     = 14,
  parameter int GAIN_W = 16
);
  logic                  enable;
  logic [2*NCH-1:0]      src_sel;
  logic [DW-1:0]         lut_data;
  logic                  lut_valid;
  logic [NCH*DW-1:0]     ext_data;
  logic [NCH-1:0]        ext_valid;
  logic [DW-1:0]         const_val;
  logic [NCH*GAIN_W-1:0] gain;
  logic [NCH-1:0]        dac_clk;
  logic [NCH*DW-1:0]     dac_data;
  logic                  dac_mode;
  logic                  power_on;
  logic                  busy;
  logic                  valid_export;

  // Driver side: consumes samples and controls, produces the DAC pins.
  modport slave (
    input  enable, src_sel, lut_data, lut_valid, ext_data, ext_valid, const_val, gain,
    output dac_clk, dac_data, dac_mode, power_on, busy, valid_export
  );

  // Source side: drives samples and controls, observes the DAC pins.
  modport master (
    output enable, src_sel, lut_data, lut_valid, ext_data, ext_valid, const_val, gain,
    input  dac_clk, dac_data, dac_mode, power_on, busy, valid_export
  );
endinterface

// File: rtl/dac_multichannel_driver.sv
// rtl/dac_multichannel_driver.sv - N-channel DAC driver with gain/saturation, ramp-to-idle and settled strobe
module dac_multichannel_driver #(
  parameter int NCH        = 2,
  parameter int DW         = 14,
  parameter int GAIN_W     = 16,
  parameter int SHIFT      = 10,
  parameter int IDLE_LEVEL = 8192,
  parameter int RAMP_STEP  = 64,
  parameter int SETTLE_DLY = 10
) (
  input logic CLK_65,
  input logic reset_n,
  dac_multichannel_driver_if.slave bus
);

  localparam int PW = DW + GAIN_W;
  localparam int CW = $clog2(SETTLE_DLY + 1);
  localparam logic [DW-1:0] IDLE_CODE = DW'(IDLE_LEVEL);
  localparam logic [DW-1:0] STEP_CODE = DW'(RAMP_STEP);
  localparam logic [DW-1:0] MAX_CODE  = {DW{1'b1}};
  localparam logic [CW-1:0] SETTLE_MAX = CW'(SETTLE_DLY);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_RAMP} state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   dac_q [NCH];
  logic [DW-1:0]   dac_d [NCH];
  logic [CW-1:0]   settle_q, settle_d;
  logic            valid_export_q, valid_export_d;

  // Stage-1 registers: ext product per channel, shared LUT/const delay, captured select and valid
  logic [PW-1:0]   prod_q [NCH];
  logic [1:0]      sel_s1_q [NCH];
  logic [NCH-1:0]  vld_s1_q;
  logic [DW-1:0]   lut_s1_q;
  logic [DW-1:0]   const_s1_q;

  logic [PW-1:0]   shifted [NCH];
  logic [DW-1:0]   s2_val [NCH];
  logic [DW-1:0]   ramp_val [NCH];
  logic [DW-1:0]   gap;
  logic            all_idle;
  logic            run_go;

  // Stage 1 only accepts strobes while actively running, which also flushes it on leaving RUN.
  assign run_go = (state_q == ST_RUN) && bus.enable;

  // Stage 1: multiply external samples, delay LUT/const samples, capture per-channel select and strobe
  always_ff @(posedge CLK_65) begin
    if (!reset_n) begin
      vld_s1_q   <= '0;
      lut_s1_q   <= IDLE_CODE;
      const_s1_q <= IDLE_CODE;
      for (int i = 0; i < NCH; i++) begin
        prod_q[i]   <= '0;
        sel_s1_q[i] <= 2'd0;
      end
    end else begin
      if (bus.lut_valid) begin
        lut_s1_q   <= bus.lut_data;
        const_s1_q <= bus.const_val;
      end
      for (int i = 0; i < NCH; i++) begin
        sel_s1_q[i] <= bus.src_sel[2*i +: 2];
        if (bus.ext_valid[i]) begin
          prod_q[i] <= PW'(bus.ext_data[i*DW +: DW]) * PW'(bus.gain[i*GAIN_W +: GAIN_W]);
        end
        vld_s1_q[i] <= run_go &&
                       ((bus.src_sel[2*i +: 2] == 2'd1) ? bus.ext_valid[i] : bus.lut_valid);
      end
    end
  end

  // Stage 2 mux: scale and saturate the product, pick the source captured with the strobe
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      shifted[i] = prod_q[i] >> SHIFT;
      s2_val[i]  = IDLE_CODE;
      case (sel_s1_q[i])
        2'd0:    s2_val[i] = lut_s1_q;
        2'd1:    s2_val[i] = (shifted[i] > PW'(MAX_CODE)) ? MAX_CODE : shifted[i][DW-1:0];
        2'd2:    s2_val[i] = const_s1_q;
        default: s2_val[i] = IDLE_CODE;
      endcase
    end
  end

  // Ramp target: each channel moves toward mid-scale by at most one step per cycle
  always_comb begin
    all_idle = 1'b1;
    gap      = '0;
    for (int i = 0; i < NCH; i++) begin
      ramp_val[i] = dac_q[i];
      if (dac_q[i] > IDLE_CODE) begin
        gap         = dac_q[i] - IDLE_CODE;
        ramp_val[i] = dac_q[i] - ((gap > STEP_CODE) ? STEP_CODE : gap);
      end else begin
        gap         = IDLE_CODE - dac_q[i];
        ramp_val[i] = dac_q[i] + ((gap > STEP_CODE) ? STEP_CODE : gap);
      end
      if (ramp_val[i] != IDLE_CODE) all_idle = 1'b0;
    end
  end

  // FSM next state, DAC codes, settle counter and settled strobe
  always_comb begin
    state_d        = state_q;
    settle_d       = settle_q;
    valid_export_d = 1'b0;
    for (int i = 0; i < NCH; i++) dac_d[i] = dac_q[i];
    case (state_q)
      ST_IDLE: begin
        settle_d = '0;
        for (int i = 0; i < NCH; i++) dac_d[i] = IDLE_CODE;
        if (bus.enable) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!bus.enable) begin
          state_d  = ST_RAMP;
          settle_d = '0;
        end else begin
          for (int i = 0; i < NCH; i++) begin
            if (vld_s1_q[i]) dac_d[i] = s2_val[i];
          end
          if (vld_s1_q[0]) begin
            valid_export_d = (settle_q == SETTLE_MAX);
            if (settle_q != SETTLE_MAX) settle_d = settle_q + CW'(1);
          end
        end
      end
      ST_RAMP: begin
        settle_d = '0;
        for (int i = 0; i < NCH; i++) dac_d[i] = ramp_val[i];
        if (all_idle) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, output code and strobe registers
  always_ff @(posedge CLK_65) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      settle_q       <= '0;
      valid_export_q <= 1'b0;
      for (int i = 0; i < NCH; i++) dac_q[i] <= IDLE_CODE;
    end else begin
      state_q        <= state_d;
      settle_q       <= settle_d;
      valid_export_q <= valid_export_d;
      for (int i = 0; i < NCH; i++) dac_q[i] <= dac_d[i];
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_out
    assign bus.dac_data[g*DW +: DW] = dac_q[g];
  end

  assign bus.dac_clk      = {NCH{CLK_65}};
  assign bus.dac_mode     = 1'b1;
  assign bus.power_on     = 1'b1;
  assign bus.busy         = (state_q != ST_IDLE);
  assign bus.valid_export = valid_export_q;

endmodule

// File: tb/tb_dac_multichannel_driver.sv
// tb/tb_dac_multichannel_driver.sv - randomized self-checking bench for dac_multichannel_driver
module tb_dac_multichannel_driver;
  localparam int NCH = 2;
  localparam int DW  = 14;
  localparam int GW  = 16;

  typedef struct {
    int due;
    int ch;
    int val;
  } ev_t;

  logic CLK_65 = 1'b0;
  logic reset_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  dac_multichannel_driver_if #(.NCH(NCH), .DW(DW), .GAIN_W(GW)) bus ();

  dac_multichannel_driver #(
    .NCH(NCH), .DW(DW), .GAIN_W(GW), .SHIFT(10), .IDLE_LEVEL(8192),
    .RAMP_STEP(64), .SETTLE_DLY(10)
  ) dut (
    .CLK_65 (CLK_65),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 CLK_65 = ~CLK_65;

  task automatic tick();
    @(posedge CLK_65);
    #1;
  endtask

  function automatic int dac(input int ch);
    return int'(bus.dac_data[ch*DW +: DW]);
  endfunction

  function automatic int scaled(input int x, input int g);
    longint p;
    p = (longint'(x) * longint'(g)) / 1024;
    return (p > 16383) ? 16383 : int'(p);
  endfunction

  function automatic int toward_idle(input int v);
    int d;
    d = (v > 8192) ? v - 8192 : 8192 - v;
    if (d > 64) d = 64;
    return (v > 8192) ? v - d : v + d;
  endfunction

  task automatic quiet_inputs();
    bus.lut_valid = 1'b0;
    bus.ext_valid = '0;
  endtask

  task automatic reset_pulse();
    quiet_inputs();
    bus.enable = 1'b0;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  // Puts ch0/ch1 at the given codes through the x1.0 external path, leaving the driver in RUN.
  task automatic prep_levels(input int a, input int b);
    reset_pulse();
    bus.enable = 1'b1;
    tick();
    bus.src_sel   = 4'b0101;
    bus.ext_data  = {DW'(b), DW'(a)};
    bus.gain      = {GW'(1024), GW'(1024)};
    bus.ext_valid = 2'b11;
    tick();
    bus.ext_valid = 2'b00;
    tick();
  endtask

  task automatic test_reset();
    bus.enable = 1'b0; bus.src_sel = '0; bus.lut_data = '0; bus.const_val = '0;
    bus.ext_data = '0; bus.gain = '0;
    quiet_inputs();
    reset_n = 1'b0;
    tick(); tick();
    for (int ch = 0; ch < NCH; ch++) begin
      vectors++;
      if (dac(ch) !== 8192) begin
        miscompares++;
        $display("FAIL reset_dac%0d: got %0d expected 8192", ch, dac(ch));
      end
    end
    vectors++;
    if (bus.busy !== 1'b0 || bus.valid_export !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_flags: busy=%b valid=%b expected 0 0", bus.busy, bus.valid_export);
    end
    vectors++;
    if (bus.dac_mode !== 1'b1 || bus.power_on !== 1'b1 || bus.dac_clk !== 2'b11) begin
      miscompares++;
      $display("FAIL const_pins: mode=%b pwr=%b clk=%b expected 1 1 11",
               bus.dac_mode, bus.power_on, bus.dac_clk);
    end
    reset_n = 1'b1;
    bus.lut_valid = 1'b1;
    repeat (5) tick();
    bus.lut_valid = 1'b0;
    for (int ch = 0; ch < NCH; ch++) begin
      vectors++;
      if (dac(ch) !== 8192 || bus.busy !== 1'b0) begin
        miscompares++;
        $display("FAIL hold_until_enable%0d: got %0d busy=%b expected 8192 busy=0", ch, dac(ch), bus.busy);
      end
    end
  endtask

  task automatic test_ext_gain();
    int tbl [3][3] = '{'{8000, 1189, 9289}, '{16383, 2048, 16383}, '{5000, 0, 0}};
    int prev = 8192;
    reset_pulse();
    bus.enable = 1'b1;
    tick();
    vectors++;
    if (bus.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL run_busy: got %b expected 1", bus.busy);
    end
    bus.src_sel = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      bus.ext_data  = {DW'(0), DW'(tbl[k][0])};
      bus.gain      = {GW'(0), GW'(tbl[k][1])};
      bus.ext_valid = 2'b01;
      tick();
      bus.ext_valid = 2'b00;
      bus.ext_data  = {DW'($urandom_range(0, 16383)), DW'($urandom_range(0, 16383))};
      vectors++;
      if (dac(0) !== prev) begin
        miscompares++;
        $display("FAIL ext_latency%0d: got %0d expected %0d after 1 cycle", k, dac(0), prev);
      end
      tick();
      vectors++;
      if (dac(0) !== tbl[k][2]) begin
        miscompares++;
        $display("FAIL ext_gain%0d: got %0d expected %0d", k, dac(0), tbl[k][2]);
      end
      repeat (3) tick();
      vectors++;
      if (dac(0) !== tbl[k][2] || dac(1) !== 8192) begin
        miscompares++;
        $display("FAIL ext_hold%0d: got %0d/%0d expected %0d/8192", k, dac(0), dac(1), tbl[k][2]);
      end
      prev = tbl[k][2];
    end
  endtask

  task automatic test_settle();
    int v;
    reset_pulse();
    bus.enable = 1'b1;
    bus.src_sel = 4'b0000;
    tick();
    for (int n = 1; n <= 14; n++) begin
      v = $urandom_range(0, 16383);
      bus.lut_data  = DW'(v);
      bus.lut_valid = 1'b1;
      tick();
      bus.lut_valid = 1'b0;
      tick();
      vectors++;
      if (dac(0) !== v || dac(1) !== v) begin
        miscompares++;
        $display("FAIL settle_data%0d: got %0d/%0d expected %0d", n, dac(0), dac(1), v);
      end
      vectors++;
      if (bus.valid_export !== (n >= 11)) begin
        miscompares++;
        $display("FAIL settle_strobe%0d: got %b expected %b", n, bus.valid_export, n >= 11);
      end
      tick();
      vectors++;
      if (bus.valid_export !== 1'b0) begin
        miscompares++;
        $display("FAIL settle_pulse_width%0d: got %b expected 0", n, bus.valid_export);
      end
    end
  endtask

  task automatic test_random();
    int   exp_v [NCH];
    int   settle = 0;
    int   cyc = 0;
    int   sel, val;
    logic strobe, exp_valid;
    ev_t  evq [$];
    ev_t  e;
    reset_pulse();
    bus.enable = 1'b1;
    tick();
    exp_v = '{8192, 8192};
    for (int c = 0; c < 400; c++) begin
      if (c % 25 == 0) bus.src_sel = 4'($urandom_range(0, 15));
      bus.lut_valid = 1'($urandom_range(0, 1));
      bus.ext_valid = 2'($urandom_range(0, 3));
      bus.lut_data  = DW'($urandom_range(0, 16383));
      bus.const_val = DW'($urandom_range(0, 16383));
      bus.ext_data  = {DW'($urandom_range(0, 16383)), DW'($urandom_range(0, 16383))};
      bus.gain      = {GW'($urandom_range(0, 4095)), GW'($urandom_range(0, 4095))};
      for (int ch = 0; ch < NCH; ch++) begin
        sel = int'(bus.src_sel[2*ch +: 2]);
        strobe = (sel == 1) ? bus.ext_valid[ch] : bus.lut_valid;
        if (strobe) begin
          case (sel)
            0:       val = int'(bus.lut_data);
            1:       val = scaled(int'(bus.ext_data[ch*DW +: DW]), int'(bus.gain[ch*GW +: GW]));
            2:       val = int'(bus.const_val);
            default: val = 8192;
          endcase
          evq.push_back('{cyc + 2, ch, val});
        end
      end
      tick();
      cyc++;
      exp_valid = 1'b0;
      while (evq.size() > 0 && evq[0].due == cyc) begin
        e = evq.pop_front();
        exp_v[e.ch] = e.val;
        if (e.ch == 0) begin
          exp_valid = (settle >= 10);
          settle++;
        end
      end
      for (int ch = 0; ch < NCH; ch++) begin
        vectors++;
        if (dac(ch) !== exp_v[ch]) begin
          miscompares++;
          $display("FAIL random_dac%0d cyc %0d: got %0d expected %0d", ch, cyc, dac(ch), exp_v[ch]);
        end
      end
      vectors++;
      if (bus.valid_export !== exp_valid) begin
        miscompares++;
        $display("FAIL random_valid cyc %0d: got %b expected %b", cyc, bus.valid_export, exp_valid);
      end
    end
    quiet_inputs();
  endtask

  task automatic test_ramp();
    int e0 = 16000;
    int e1 = 8000;
    int steps = 0;
    prep_levels(16000, 8000);
    vectors++;
    if (dac(0) !== 16000 || dac(1) !== 8000) begin
      miscompares++;
      $display("FAIL ramp_preload: got %0d/%0d expected 16000/8000", dac(0), dac(1));
    end
    bus.enable = 1'b0;
    tick();
    vectors++;
    if (dac(0) !== 16000 || dac(1) !== 8000 || bus.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL ramp_entry: got %0d/%0d busy=%b expected 16000/8000 busy=1", dac(0), dac(1), bus.busy);
    end
    while (steps < 300) begin
      tick();
      steps++;
      e0 = toward_idle(e0);
      e1 = toward_idle(e1);
      vectors++;
      if (dac(0) !== e0 || dac(1) !== e1 || bus.busy !== (e0 != 8192 || e1 != 8192)) begin
        miscompares++;
        $display("FAIL ramp_step%0d: got %0d/%0d busy=%b expected %0d/%0d", steps, dac(0), dac(1), bus.busy, e0, e1);
      end
      if (e0 == 8192 && e1 == 8192) break;
    end
    vectors++;
    if (steps !== 122) begin
      miscompares++;
      $display("FAIL ramp_length: got %0d cycles expected 122", steps);
    end
  endtask

  task automatic test_reset_mid_ramp();
    prep_levels(16000, 300);
    bus.enable = 1'b0;
    tick();
    repeat (10) tick();
    vectors++;
    if (dac(0) !== 15360 || dac(1) !== 940) begin
      miscompares++;
      $display("FAIL midramp_level: got %0d/%0d expected 15360/940", dac(0), dac(1));
    end
    reset_n = 1'b0;
    tick();
    vectors++;
    if (dac(0) !== 8192 || dac(1) !== 8192 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL midramp_reset: got %0d/%0d busy=%b expected 8192/8192 busy=0", dac(0), dac(1), bus.busy);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_enable_mid_ramp();
    int steps = 10;
    int pulses = 0;
    int first_pulse = 0;
    prep_levels(16000, 8000);
    bus.enable = 1'b0;
    tick();
    repeat (10) tick();
    bus.enable = 1'b1;
    while (bus.busy === 1'b1 && steps < 300) begin
      tick();
      steps++;
    end
    vectors++;
    if (steps !== 122 || dac(0) !== 8192 || dac(1) !== 8192) begin
      miscompares++;
      $display("FAIL toggle_ramp: got %0d cycles %0d/%0d expected 122 8192/8192", steps, dac(0), dac(1));
    end
    tick();
    vectors++;
    if (bus.busy !== 1'b1) begin
      miscompares++;
      $display("FAIL toggle_rerun: busy got %b expected 1", bus.busy);
    end
    bus.src_sel = 4'b0000;
    for (int n = 1; n <= 11; n++) begin
      bus.lut_data  = DW'($urandom_range(0, 16383));
      bus.lut_valid = 1'b1;
      tick();
      bus.lut_valid = 1'b0;
      tick();
      if (bus.valid_export === 1'b1) begin
        pulses++;
        if (first_pulse == 0) first_pulse = n;
      end
    end
    vectors++;
    if (pulses !== 1 || first_pulse !== 11) begin
      miscompares++;
      $display("FAIL toggle_settle: got %0d pulses first at %0d expected 1 at 11", pulses, first_pulse);
    end
  endtask

  initial begin
    test_reset();
    test_ext_gain();
    test_settle();
    test_random();
    test_ramp();
    test_reset_mid_ramp();
    test_enable_mid_ramp();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
